clock_set_ctrl: RTL and testbench

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

---
 rtl/clock_set_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// Clock time-set controller: 1 s tick generation in RUN, interactive
// hours/minutes editing with blinking digits, inactivity abort, and a
// one-cycle load strobe that hands the edited time to the datapath.
//
// state   | meaning
// RUN     | normal timekeeping, tick_en_o pulses once per second
// SET_HRS | editing hours, hour digits blink
// SET_MIN | editing minutes, minute digits blink
// COMMIT  | one cycle, load_o=1 with edited time on ld_*
module clock_set_ctrl #(
    parameter int TICK_DIV  = 100000000,
    parameter int BLINK_DIV = 25000000,
    parameter int IDLE_SECS = 30
) (
    input  logic       CLK100MHZ,
    input  logic       Reset,
    input  logic       mode_btn_i,
    input  logic       inc_btn_i,
    input  logic [3:0] cur_h2_i,
    input  logic [3:0] cur_h1_i,
    input  logic [3:0] cur_m2_i,
    input  logic [3:0] cur_m1_i,
    output logic       tick_en_o,
    output logic       load_o,
    output logic [3:0] ld_h2_o,
    output logic [3:0] ld_h1_o,
    output logic [3:0] ld_m2_o,
    output logic [3:0] ld_m1_o,
    output logic [3:0] blank_mask_o,
    output logic [1:0] mode_o
);

    localparam int TW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int IW = (IDLE_SECS > 1) ? $clog2(IDLE_SECS) : 1;

    localparam logic [TW-1:0] TICK_MAX  = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_SECS - 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HRS = 2'd1,
        SET_MIN = 2'd2,
        COMMIT  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic          tick_en_q, tick_en_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          phase_q, phase_d;
    logic [TW-1:0] pre_q, pre_d;
    logic [IW-1:0] sec_q, sec_d;
    logic [3:0]    e_h2_q, e_h1_q, e_m2_q, e_m1_q;
    logic [3:0]    e_h2_d, e_h1_d, e_m2_d, e_m1_d;
    logic [3:0]    ld_h2_q, ld_h1_q, ld_m2_q, ld_m1_q;
    logic [3:0]    ld_h2_d, ld_h1_d, ld_m2_d, ld_m1_d;

    logic in_set, set_d, idle_expire, restart;

    // Next state, edit-register arithmetic and load-value capture.
    always_comb begin
        state_d = state_q;
        e_h2_d  = e_h2_q;
        e_h1_d  = e_h1_q;
        e_m2_d  = e_m2_q;
        e_m1_d  = e_m1_q;
        ld_h2_d = ld_h2_q;
        ld_h1_d = ld_h1_q;
        ld_m2_d = ld_m2_q;
        ld_m1_d = ld_m1_q;
        in_set      = (state_q == SET_HRS) || (state_q == SET_MIN);
        idle_expire = in_set && (pre_q == TICK_MAX) && (sec_q == IDLE_MAX);
        case (state_q)
            RUN: begin
                if (mode_btn_i) begin
                    state_d = SET_HRS;
                    e_h2_d  = cur_h2_i;
                    e_h1_d  = cur_h1_i;
                    e_m2_d  = cur_m2_i;
                    e_m1_d  = cur_m1_i;
                end
            end
            SET_HRS: begin
                if (mode_btn_i) begin
                    state_d = SET_MIN;
                end else if (inc_btn_i) begin
                    if (e_h2_q == 4'd2 && e_h1_q == 4'd3) begin
                        e_h2_d = 4'd0;
                        e_h1_d = 4'd0;
                    end else if (e_h1_q == 4'd9) begin
                        e_h1_d = 4'd0;
                        e_h2_d = e_h2_q + 4'd1;
                    end else begin
                        e_h1_d = e_h1_q + 4'd1;
                    end
                end else if (idle_expire) begin
                    state_d = RUN;
                end
            end
            SET_MIN: begin
                if (mode_btn_i) begin
                    state_d = COMMIT;
                    ld_h2_d = e_h2_q;
                    ld_h1_d = e_h1_q;
                    ld_m2_d = e_m2_q;
                    ld_m1_d = e_m1_q;
                end else if (inc_btn_i) begin
                    if (e_m1_q == 4'd9) begin
                        e_m1_d = 4'd0;
                        e_m2_d = (e_m2_q == 4'd5) ? 4'd0 : e_m2_q + 4'd1;
                    end else begin
                        e_m1_d = e_m1_q + 4'd1;
                    end
                end else if (idle_expire) begin
                    state_d = RUN;
                end
            end
            COMMIT: state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Tick, blink and idle counters; all restart on set-state entry or button activity.
    always_comb begin
        set_d   = (state_d == SET_HRS) || (state_d == SET_MIN);
        restart = (in_set && (mode_btn_i || inc_btn_i)) || (set_d && (state_d != state_q));
        tick_d    = '0;
        tick_en_d = (state_q == RUN) && (tick_q == TICK_MAX);
        if (state_q == RUN && state_d == RUN) begin
            tick_d = (tick_q == TICK_MAX) ? '0 : tick_q + TW'(1);
        end
        blink_d = '0;
        phase_d = 1'b0;
        pre_d   = '0;
        sec_d   = '0;
        if (set_d && !restart) begin
            if (blink_q == BLINK_MAX) begin
                blink_d = '0;
                phase_d = ~phase_q;
            end else begin
                blink_d = blink_q + BW'(1);
                phase_d = phase_q;
            end
            if (pre_q == TICK_MAX) begin
                pre_d = '0;
                sec_d = (sec_q == IDLE_MAX) ? sec_q : sec_q + IW'(1);
            end else begin
                pre_d = pre_q + TW'(1);
                sec_d = sec_q;
            end
        end
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge CLK100MHZ) begin
        if (Reset) begin
            state_q   <= RUN;
            tick_q    <= '0;
            tick_en_q <= 1'b0;
            blink_q   <= '0;
            phase_q   <= 1'b0;
            pre_q     <= '0;
            sec_q     <= '0;
            e_h2_q    <= 4'd0;
            e_h1_q    <= 4'd0;
            e_m2_q    <= 4'd0;
            e_m1_q    <= 4'd0;
            ld_h2_q   <= 4'd0;
            ld_h1_q   <= 4'd0;
            ld_m2_q   <= 4'd0;
            ld_m1_q   <= 4'd0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            tick_en_q <= tick_en_d;
            blink_q   <= blink_d;
            phase_q   <= phase_d;
            pre_q     <= pre_d;
            sec_q     <= sec_d;
            e_h2_q    <= e_h2_d;
            e_h1_q    <= e_h1_d;
            e_m2_q    <= e_m2_d;
            e_m1_q    <= e_m1_d;
            ld_h2_q   <= ld_h2_d;
            ld_h1_q   <= ld_h1_d;
            ld_m2_q   <= ld_m2_d;
            ld_m1_q   <= ld_m1_d;
        end
    end

    // Blank the digits under edit during the blank phase of the blink.
    always_comb begin
        blank_mask_o = 4'b0000;
        if (phase_q) begin
            if (state_q == SET_HRS) begin
                blank_mask_o = 4'b1100;
            end else if (state_q == SET_MIN) begin
                blank_mask_o = 4'b0011;
            end
        end
    end

    // Load is gated by Reset so a reset landing on COMMIT never loads.
    assign load_o    = (state_q == COMMIT) && !Reset;
    assign tick_en_o = tick_en_q;
    assign mode_o    = state_q;
    assign ld_h2_o   = ld_h2_q;
    assign ld_h1_o   = ld_h1_q;
    assign ld_m2_o   = ld_m2_q;
    assign ld_m1_o   = ld_m1_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with small divider parameters.
module tb_clock_set_ctrl;

    logic       clk;
    logic       rst;
    logic       mode_btn, inc_btn;
    logic [3:0] cur_h2, cur_h1, cur_m2, cur_m1;
    logic       tick_en, load;
    logic [3:0] ld_h2, ld_h1, ld_m2, ld_m1;
    logic [3:0] blank_mask;
    logic [1:0] mode;

    int n_checks = 0;
    int n_fail   = 0;

    clock_set_ctrl #(
        .TICK_DIV (10),
        .BLINK_DIV(4),
        .IDLE_SECS(3)
    ) dut (
        .CLK100MHZ   (clk),
        .Reset       (rst),
        .mode_btn_i  (mode_btn),
        .inc_btn_i   (inc_btn),
        .cur_h2_i    (cur_h2),
        .cur_h1_i    (cur_h1),
        .cur_m2_i    (cur_m2),
        .cur_m1_i    (cur_m1),
        .tick_en_o   (tick_en),
        .load_o      (load),
        .ld_h2_o     (ld_h2),
        .ld_h1_o     (ld_h1),
        .ld_m2_o     (ld_m2),
        .ld_m1_o     (ld_m1),
        .blank_mask_o(blank_mask),
        .mode_o      (mode)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        mode_btn;
        logic        inc_btn;
        logic [15:0] cur;
        logic [1:0]  exp_mode;
        logic        exp_load;
        logic [15:0] exp_ld;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic m, input logic i, input logic [15:0] c,
                       input logic [1:0] em, input logic el, input logic [15:0] eld);
        vec_t v;
        v.mode_btn = m;
        v.inc_btn  = i;
        v.cur      = c;
        v.exp_mode = em;
        v.exp_load = el;
        v.exp_ld   = eld;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cur(input logic [15:0] c);
        {cur_h2, cur_h1, cur_m2, cur_m1} = c;
    endtask

    task automatic press(input logic m, input logic i);
        mode_btn = m;
        inc_btn  = i;
        step();
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
    endtask

    function automatic logic [15:0] ld_all();
        return {ld_h2, ld_h1, ld_m2, ld_m1};
    endfunction

    initial begin
        rst = 1'b1;
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
        set_cur(16'h0000);

        // Directed table: cur 12:09 minute edit with mode+inc collision,
        // cur 23:59 wrap to 00:00, cur 09:45 hour carry and ignored buttons.
        add(1, 0, 16'h1209, 2'd1, 0, 16'h0000);
        add(1, 0, 16'h1209, 2'd2, 0, 16'h0000);
        add(0, 1, 16'h1209, 2'd2, 0, 16'h0000);
        add(1, 1, 16'h1209, 2'd3, 1, 16'h1210);
        add(0, 0, 16'h1209, 2'd0, 0, 16'h1210);
        add(1, 0, 16'h2359, 2'd1, 0, 16'h1210);
        add(0, 1, 16'h2359, 2'd1, 0, 16'h1210);
        add(1, 0, 16'h2359, 2'd2, 0, 16'h1210);
        add(0, 1, 16'h2359, 2'd2, 0, 16'h1210);
        add(1, 0, 16'h2359, 2'd3, 1, 16'h0000);
        add(0, 0, 16'h2359, 2'd0, 0, 16'h0000);
        add(1, 0, 16'h0945, 2'd1, 0, 16'h0000);
        add(0, 1, 16'h0945, 2'd1, 0, 16'h0000);
        add(1, 0, 16'h0945, 2'd2, 0, 16'h0000);
        add(0, 1, 16'h0945, 2'd2, 0, 16'h0000);
        add(1, 0, 16'h0945, 2'd3, 1, 16'h1046);
        add(1, 1, 16'h0945, 2'd0, 0, 16'h1046);
        add(0, 1, 16'h0945, 2'd0, 0, 16'h1046);
        add(0, 0, 16'h0945, 2'd0, 0, 16'h1046);

        // Reset state
        repeat (3) step();
        check("rst_mode", mode, 0);
        check("rst_load", load, 0);
        check("rst_tick", tick_en, 0);
        check("rst_blank", blank_mask, 0);
        check("rst_ld", ld_all(), 0);
        rst = 1'b0;

        // Free-running ticks after release
        for (int c = 1; c <= 35; c++) begin
            step();
            check("run_tick", tick_en, (c % 10 == 0) ? 1 : 0);
            check("run_mode", mode, 0);
            check("run_load", load, 0);
        end

        // Table-driven edit sequences
        for (int i = 0; i < vecs.size(); i++) begin
            set_cur(vecs[i].cur);
            press(vecs[i].mode_btn, vecs[i].inc_btn);
            check("vec_mode", mode, vecs[i].exp_mode);
            check("vec_load", load, vecs[i].exp_load);
            check("vec_ld", ld_all(), vecs[i].exp_ld);
            check("vec_blank", blank_mask, 0);
        end

        // Hour blink pattern and restart on inc
        press(1, 0);
        check("hrs_mode", mode, 1);
        check("hrs_blink", blank_mask, 0);
        for (int i = 1; i <= 5; i++) begin
            step();
            check("hrs_blink", blank_mask, ((i / 4) % 2 == 1) ? 4'b1100 : 4'b0000);
        end
        press(0, 1);
        check("hrs_inc_blink", blank_mask, 0);
        for (int j = 1; j <= 7; j++) begin
            step();
            check("hrs_inc_blink", blank_mask, (j >= 4) ? 4'b1100 : 4'b0000);
        end

        // Minute blink, idle abort, tick restart from zero
        press(1, 0);
        check("min_mode", mode, 2);
        check("min_blink", blank_mask, 0);
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k < 30) begin
                check("idle_mode", mode, 2);
                check("min_blink", blank_mask, ((k / 4) % 2 == 1) ? 4'b0011 : 4'b0000);
            end else begin
                check("idle_mode", mode, 0);
                check("idle_blank", blank_mask, 0);
                check("idle_tick", tick_en, (k == 40) ? 1 : 0);
            end
            check("idle_load", load, 0);
            check("idle_ld", ld_all(), 16'h1046);
        end

        // Reset mid-edit discards edits and clears outputs
        set_cur(16'h1530);
        press(1, 0);
        press(0, 1);
        press(1, 0);
        press(0, 1);
        check("pre_rst_mode", mode, 2);
        rst = 1'b1;
        mode_btn = 1'b1;
        step();
        mode_btn = 1'b0;
        rst = 1'b0;
        check("midrst_mode", mode, 0);
        check("midrst_blank", blank_mask, 0);
        check("midrst_ld", ld_all(), 0);
        check("midrst_load", load, 0);
        step();
        check("midrst_mode2", mode, 0);
        check("midrst_load2", load, 0);

        // Reset landing on COMMIT suppresses load
        set_cur(16'h0730);
        press(1, 0);
        press(1, 0);
        press(1, 0);
        check("cmt_mode", mode, 3);
        check("cmt_load", load, 1);
        check("cmt_ld", ld_all(), 16'h0730);
        rst = 1'b1;
        #1;
        check("cmt_rst_load", load, 0);
        step();
        check("cmt_rst_mode", mode, 0);
        check("cmt_rst_ld", ld_all(), 0);
        check("cmt_rst_tick", tick_en, 0);
        rst = 1'b0;
        step();
        check("cmt_after_load", load, 0);
        check("cmt_after_mode", mode, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
